// File: rtl/wbm_rr_arbiter.sv
// -----------------------------------------------------------------------------
// wbm_rr_arbiter
//   Round-robin arbiter that shares one downstream Wishbone master port
//   between NUM_MASTERS upstream masters. One transaction is in flight at a
//   time. The winner's request is latched and presented downstream as a
//   single-cycle cyc/stb pulse. The response (ack/err/data) is steered back
//   to the winner. A local timeout errors the winner if the slave never
//   answers.
//
//   Sequence per transaction: IDLE -> WAIT (1..TIMEOUT cycles) -> DONE -> IDLE.
//   All outputs are registered.
//
// Ports
//   wb_clk_i / wb_rst_i      clock, synchronous active-high reset
//   wbm_cyc/stb/we_i         per-master control, one bit per master
//   wbm_sel_i                byte selects, master m at [4m+3:4m]
//   wbm_adr_i / wbm_dat_i    address / write data, master m at [32m+31:32m]
//   wbm_dat_o                read data shared by all masters (updates on ack)
//   wbm_ack_o / wbm_err_o    per-master one-cycle response pulses
//   wbs_*_o                  downstream request (latched, cyc/stb one cycle)
//   wbs_dat/ack/err_i        downstream response
//   grant_o                  one-hot current owner, zero when idle
// -----------------------------------------------------------------------------
module wbm_rr_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int TIMEOUT     = 1024
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic [NUM_MASTERS-1:0]    wbm_cyc_i,
  input  logic [NUM_MASTERS-1:0]    wbm_stb_i,
  input  logic [NUM_MASTERS-1:0]    wbm_we_i,
  input  logic [4*NUM_MASTERS-1:0]  wbm_sel_i,
  input  logic [32*NUM_MASTERS-1:0] wbm_adr_i,
  input  logic [32*NUM_MASTERS-1:0] wbm_dat_i,
  output logic [31:0]               wbm_dat_o,
  output logic [NUM_MASTERS-1:0]    wbm_ack_o,
  output logic [NUM_MASTERS-1:0]    wbm_err_o,
  output logic                      wbs_cyc_o,
  output logic                      wbs_stb_o,
  output logic                      wbs_we_o,
  output logic [3:0]                wbs_sel_o,
  output logic [31:0]               wbs_adr_o,
  output logic [31:0]               wbs_dat_o,
  input  logic [31:0]               wbs_dat_i,
  input  logic                      wbs_ack_i,
  input  logic                      wbs_err_i,
  output logic [NUM_MASTERS-1:0]    grant_o
);

  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
  } wb_req_t;

  // ---------------------------------------------------------------------------
  // Per-master request unpacking
  // ---------------------------------------------------------------------------
  wb_req_t                mreq [NUM_MASTERS];
  logic [NUM_MASTERS-1:0] req;

  assign req = wbm_cyc_i & wbm_stb_i;

  for (genvar m = 0; m < NUM_MASTERS; m++) begin : g_unpack
    assign mreq[m] = {wbm_we_i[m], wbm_sel_i[4*m +: 4],
                      wbm_adr_i[32*m +: 32], wbm_dat_i[32*m +: 32]};
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e                 state_q;
  logic [IW-1:0]          last_q;    // last granted master (rr pointer)
  logic [IW-1:0]          win_q;     // owner of the transaction in flight
  logic [CW-1:0]          cnt_q;     // WAIT cycles elapsed
  logic                   abort_q;   // owner dropped cyc during this WAIT
  logic [NUM_MASTERS-1:0] grant_q;
  logic [NUM_MASTERS-1:0] ack_q;
  logic [NUM_MASTERS-1:0] err_q;
  logic [31:0]            rdat_q;
  logic                   cyc_q;
  wb_req_t                lreq_q;

  // ---------------------------------------------------------------------------
  // Round-robin pick. Offsets are scanned from farthest to nearest so the
  // nearest requester after last_q overwrites the others and wins.
  // ---------------------------------------------------------------------------
  logic          pick_vld_d;
  logic [IW-1:0] pick_idx_d;

  always_comb begin
    int            cand;
    logic [IW-1:0] cidx;
    pick_vld_d = 1'b0;
    pick_idx_d = '0;
    cand       = 0;
    cidx       = '0;
    for (int i = NUM_MASTERS; i >= 1; i--) begin
      cand = (int'(last_q) + i) % NUM_MASTERS;
      cidx = IW'(cand);
      if (req[cidx]) begin
        pick_vld_d = 1'b1;
        pick_idx_d = cidx;
      end
    end
  end

  // One-hot forms of the new pick and of the current owner
  logic [NUM_MASTERS-1:0] grant_d;
  logic [NUM_MASTERS-1:0] win_oh;

  always_comb begin
    grant_d = '0;
    win_oh  = '0;
    for (int m = 0; m < NUM_MASTERS; m++) begin
      grant_d[m] = (pick_idx_d == IW'(m));
      win_oh[m]  = (win_q == IW'(m));
    end
  end

  // ---------------------------------------------------------------------------
  // WAIT-state helpers
  // ---------------------------------------------------------------------------
  logic [CW-1:0] cnt_d;
  logic          abort_d;
  logic          timeout_hit;

  assign cnt_d       = cnt_q + CW'(1);
  // A cyc drop sampled on the same edge as the response also discards it
  assign abort_d     = abort_q | ~wbm_cyc_i[win_q];
  assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

  // ---------------------------------------------------------------------------
  // FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      last_q  <= IW'(NUM_MASTERS - 1);
      win_q   <= '0;
      cnt_q   <= '0;
      abort_q <= 1'b0;
      grant_q <= '0;
      ack_q   <= '0;
      err_q   <= '0;
      rdat_q  <= '0;
      cyc_q   <= 1'b0;
      lreq_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          ack_q <= '0;
          err_q <= '0;
          cyc_q <= 1'b0;
          if (pick_vld_d) begin
            grant_q <= grant_d;
            last_q  <= pick_idx_d;
            win_q   <= pick_idx_d;
            lreq_q  <= mreq[pick_idx_d];
            cyc_q   <= 1'b1;
            cnt_q   <= '0;
            abort_q <= 1'b0;
            state_q <= S_WAIT;
          end
        end

        S_WAIT: begin
          cyc_q   <= 1'b0;
          cnt_q   <= cnt_d;
          abort_q <= abort_d;
          if (wbs_ack_i) begin
            if (!abort_d) begin
              rdat_q <= wbs_dat_i;
              ack_q  <= win_oh;
            end
            state_q <= S_DONE;
          end else if (wbs_err_i || timeout_hit) begin
            if (!abort_d) begin
              err_q <= win_oh;
            end
            state_q <= S_DONE;
          end
        end

        S_DONE: begin
          // Response pulse has been visible for exactly this cycle; the
          // master gets this cycle to drop stb before arbitration resumes.
          ack_q   <= '0;
          err_q   <= '0;
          grant_q <= '0;
          cnt_q   <= '0;
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign wbm_dat_o = rdat_q;
  assign wbm_ack_o = ack_q;
  assign wbm_err_o = err_q;
  assign wbs_cyc_o = cyc_q;
  assign wbs_stb_o = cyc_q;
  assign wbs_we_o  = lreq_q.we;
  assign wbs_sel_o = lreq_q.sel;
  assign wbs_adr_o = lreq_q.adr;
  assign wbs_dat_o = lreq_q.dat;
  assign grant_o   = grant_q;

endmodule

// File: tb/tb_wbm_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wbm_rr_arbiter
//   Directed scenarios with literal expectations, then randomized traffic.
//   A transaction-level reference model predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_wbm_rr_arbiter;

  localparam int N   = 3;
  localparam int TMO = 8;

  logic              clk;
  logic              wb_rst_i;
  logic [N-1:0]      wbm_cyc_i, wbm_stb_i, wbm_we_i;
  logic [4*N-1:0]    wbm_sel_i;
  logic [32*N-1:0]   wbm_adr_i, wbm_dat_i;
  logic [31:0]       wbm_dat_o;
  logic [N-1:0]      wbm_ack_o, wbm_err_o;
  logic              wbs_cyc_o, wbs_stb_o, wbs_we_o;
  logic [3:0]        wbs_sel_o;
  logic [31:0]       wbs_adr_o, wbs_dat_o;
  logic [31:0]       wbs_dat_i;
  logic              wbs_ack_i, wbs_err_i;
  logic [N-1:0]      grant_o;

  wbm_rr_arbiter #(.NUM_MASTERS(N), .TIMEOUT(TMO)) dut (
    .wb_clk_i (clk),       .wb_rst_i (wb_rst_i),
    .wbm_cyc_i(wbm_cyc_i), .wbm_stb_i(wbm_stb_i), .wbm_we_i(wbm_we_i),
    .wbm_sel_i(wbm_sel_i), .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i),
    .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o),
    .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_we_o(wbs_we_o),
    .wbs_sel_o(wbs_sel_o), .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o),
    .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i),
    .grant_o  (grant_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: tracks the transaction in flight by owner and age.
  // ---------------------------------------------------------------------------
  bit          mvalid = 0;
  int          m_owner, m_last, m_age, mc;
  bit          m_fin, m_abort, m_found;
  logic [N-1:0] e_grant, e_ack, e_err;
  logic        e_cyc, e_we;
  logic [3:0]  e_sel;
  logic [31:0] e_adr, e_wdat, e_rdat;

  always @(posedge clk) begin
    if (wb_rst_i) begin
      mvalid = 1; m_owner = -1; m_last = N - 1; m_age = 0; m_fin = 0; m_abort = 0;
      e_grant = '0; e_ack = '0; e_err = '0; e_cyc = 0;
      e_we = 0; e_sel = '0; e_adr = '0; e_wdat = '0; e_rdat = '0;
    end else if (mvalid) begin
      e_ack = '0; e_err = '0; e_cyc = 0;
      if (m_owner < 0) begin
        m_found = 0;
        for (int k = 1; k <= N; k++) begin
          mc = (m_last + k) % N;
          if (!m_found && wbm_cyc_i[mc] && wbm_stb_i[mc]) begin
            m_found = 1; m_owner = mc; m_last = mc; m_age = 0; m_abort = 0; m_fin = 0;
            e_grant = '0; e_grant[mc] = 1'b1; e_cyc = 1;
            e_we = wbm_we_i[mc]; e_sel = wbm_sel_i[4*mc +: 4];
            e_adr = wbm_adr_i[32*mc +: 32]; e_wdat = wbm_dat_i[32*mc +: 32];
          end
        end
      end else if (m_fin) begin
        m_owner = -1; e_grant = '0; m_fin = 0;
      end else begin
        m_age++;
        if (!wbm_cyc_i[m_owner]) m_abort = 1;
        if (wbs_ack_i) begin
          if (!m_abort) begin e_ack[m_owner] = 1'b1; e_rdat = wbs_dat_i; end
          m_fin = 1;
        end else if (wbs_err_i || m_age == TMO) begin
          if (!m_abort) e_err[m_owner] = 1'b1;
          m_fin = 1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Compare process + event monitor (negedge, away from the active edge)
  // ---------------------------------------------------------------------------
  int pulses = 0, acks_seen = 0, cyc_n = 0;
  int glog[$];

  always @(posedge clk) cyc_n++;

  always @(negedge clk) begin
    if (mvalid) begin
      chk("grant", 32'(grant_o), 32'(e_grant));
      chk("wbs_cyc", 32'(wbs_cyc_o), 32'(e_cyc));
      chk("wbs_stb", 32'(wbs_stb_o), 32'(e_cyc));
      chk("wbs_we", 32'(wbs_we_o), 32'(e_we));
      chk("wbs_sel", 32'(wbs_sel_o), 32'(e_sel));
      chk("wbs_adr", wbs_adr_o, e_adr);
      chk("wbs_dat", wbs_dat_o, e_wdat);
      chk("wbm_dat", wbm_dat_o, e_rdat);
      chk("wbm_ack", 32'(wbm_ack_o), 32'(e_ack));
      chk("wbm_err", 32'(wbm_err_o), 32'(e_err));
    end
    if (wbs_stb_o) begin
      pulses++;
      for (int m = 0; m < N; m++) if (grant_o[m]) glog.push_back(m);
    end
    if (|wbm_ack_o) acks_seen++;
  end

  // ---------------------------------------------------------------------------
  // Downstream responder. kind: 0 none, 1 ack, 2 err, 3 ack+err.
  // ---------------------------------------------------------------------------
  int          rsp_kind = 1, rsp_delay = 0, r_kind = 0, r_cd = 0;
  logic [31:0] rsp_data = '0;
  bit          r_pend = 0, rand_mode = 0, force_ack = 0;

  always @(posedge clk) begin
    #2;
    wbs_ack_i = force_ack; wbs_err_i = 1'b0; wbs_dat_i = $urandom;
    if (wbs_cyc_o) begin
      r_pend = 1; r_cd = rsp_delay; r_kind = rsp_kind;
      if (rand_mode) begin
        mc = $urandom_range(0, 9);
        r_kind = (mc < 6) ? 1 : (mc < 8) ? 2 : (mc == 8) ? 3 : 0;
        r_cd = $urandom_range(0, 9);
        rsp_data = $urandom;
      end
    end
    if (r_pend) begin
      if (r_cd == 0) begin
        r_pend = 0;
        if (r_kind == 1 || r_kind == 3) begin wbs_ack_i = 1'b1; wbs_dat_i = rsp_data; end
        if (r_kind == 2 || r_kind == 3) wbs_err_i = 1'b1;
      end else r_cd--;
    end
    if (rand_mode && $urandom_range(0, 31) == 0) wbs_ack_i = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_m(input int m, input bit c, input bit s, input bit we,
                       input logic [3:0] sel, input logic [31:0] adr, input logic [31:0] dat);
    wbm_cyc_i[m] = c; wbm_stb_i[m] = s; wbm_we_i[m] = we;
    wbm_sel_i[4*m +: 4] = sel; wbm_adr_i[32*m +: 32] = adr; wbm_dat_i[32*m +: 32] = dat;
  endtask

  task automatic drop_all();
    wbm_cyc_i = '0; wbm_stb_i = '0;
  endtask

  task automatic do_reset();
    drop_all();
    wb_rst_i = 1'b1;
    step(); step();
    wb_rst_i = 1'b0;
  endtask

  // kind: 0 ack[m], 1 err[m], 2 downstream pulse. Leaves time at negedge+1
  // of the cycle where the event is visible.
  task automatic wait_sig(input int kind, input int m, input string nm);
    bit hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clk); #1;
      case (kind)
        0:       hit = wbm_ack_o[m];
        1:       hit = wbm_err_o[m];
        default: hit = wbs_stb_o;
      endcase
    end
    chk(nm, 32'(hit), 32'd1);
  endtask

  bit [N-1:0] active;
  int         pc;

  initial begin
    wb_rst_i = 1'b1;
    wbm_cyc_i = '0; wbm_stb_i = '0; wbm_we_i = '0;
    wbm_sel_i = '0; wbm_adr_i = '0; wbm_dat_i = '0;
    wbs_ack_i = 1'b0; wbs_err_i = 1'b0; wbs_dat_i = '0;
    active = '0;

    // Reset state
    do_reset();
    @(negedge clk); #1;
    chk("rst_grant", 32'(grant_o), 32'd0);
    chk("rst_cyc", 32'(wbs_cyc_o), 32'd0);
    chk("rst_adr", wbs_adr_o, 32'd0);
    chk("rst_rdat", wbm_dat_o, 32'd0);

    // Single read
    rsp_kind = 1; rsp_delay = 3; rsp_data = 32'hDEADBEEF; pulses = 0;
    set_m(0, 1, 1, 0, 4'h0, 32'h0000_0100, 32'h0);
    wait_sig(2, 0, "rd_pulse");
    chk("rd_adr", wbs_adr_o, 32'h0000_0100);
    wait_sig(0, 0, "rd_ack");
    chk("rd_dat", wbm_dat_o, 32'hDEADBEEF);
    chk("rd_pulses", 32'(pulses), 32'd1);
    drop_all();
    step(); @(negedge clk); #1;
    chk("rd_grant_clr", 32'(grant_o), 32'd0);
    chk("rd_ack_width", 32'(wbm_ack_o), 32'd0);

    // Round-robin between masters 0 and 1
    do_reset();
    rsp_kind = 1; rsp_delay = 0; glog.delete();
    set_m(0, 1, 1, 0, 4'hF, 32'h10, 32'h0);
    set_m(1, 1, 1, 0, 4'hF, 32'h20, 32'h0);
    for (int i = 0; i < 80 && glog.size() < 4; i++) step();
    drop_all();
    chk("rr_count", 32'(glog.size() >= 4), 32'd1);
    if (glog.size() >= 4) begin
      chk("rr_g0", 32'(glog[0]), 32'd0);
      chk("rr_g1", 32'(glog[1]), 32'd1);
      chk("rr_g2", 32'(glog[2]), 32'd0);
      chk("rr_g3", 32'(glog[3]), 32'd1);
    end
    repeat (10) step();

    // Timeout then late ack
    do_reset();
    rsp_kind = 0; pulses = 0;
    set_m(2, 1, 1, 0, 4'h3, 32'h300, 32'h0);
    wait_sig(2, 2, "to_pulse");
    pc = cyc_n;
    wait_sig(1, 2, "to_err");
    chk("to_cycles", 32'(cyc_n - pc), 32'(TMO));
    drop_all();
    acks_seen = 0;
    step(); step();
    force_ack = 1; step(); force_ack = 0;
    repeat (3) step();
    chk("to_late_ack", 32'(acks_seen), 32'd0);
    chk("to_pulses", 32'(pulses), 32'd1);

    // Ack and err together: ack wins
    rsp_kind = 3; rsp_delay = 1; rsp_data = 32'hCAFEF00D;
    set_m(1, 1, 1, 0, 4'hF, 32'h400, 32'h0);
    wait_sig(0, 1, "both_ack");
    chk("both_err", 32'(wbm_err_o), 32'd0);
    chk("both_dat", wbm_dat_o, 32'hCAFEF00D);
    drop_all(); repeat (3) step();
    // Err alone leaves read data untouched
    rsp_kind = 2; rsp_delay = 2;
    set_m(0, 1, 1, 0, 4'hF, 32'h500, 32'h0);
    wait_sig(1, 0, "err_err");
    chk("err_ack", 32'(wbm_ack_o), 32'd0);
    chk("err_dat", wbm_dat_o, 32'hCAFEF00D);
    drop_all(); repeat (3) step();

    // Write with strobe held past the ack
    rsp_kind = 1; rsp_delay = 1; rsp_data = 32'h0; pulses = 0;
    set_m(1, 1, 1, 1, 4'hF, 32'h200, 32'h12345678);
    wait_sig(2, 1, "wr_pulse");
    chk("wr_we", 32'(wbs_we_o), 32'd1);
    chk("wr_sel", 32'(wbs_sel_o), 32'hF);
    chk("wr_dat", wbs_dat_o, 32'h12345678);
    wait_sig(0, 1, "wr_ack");
    step(); @(negedge clk); #1;
    chk("held_no_pulse", 32'(wbs_stb_o), 32'd0);
    drop_all();
    repeat (3) step();
    chk("held_pulses", 32'(pulses), 32'd1);

    // Reset in the middle of WAIT
    do_reset();
    rsp_kind = 0;
    set_m(1, 1, 1, 1, 4'h5, 32'h600, 32'h77);
    wait_sig(2, 1, "rw_pulse");
    step(); step();
    wb_rst_i = 1'b1; step();
    @(negedge clk); #1;
    chk("rw_grant", 32'(grant_o), 32'd0);
    chk("rw_adr", wbs_adr_o, 32'd0);
    chk("rw_err", 32'(wbm_err_o), 32'd0);
    wb_rst_i = 1'b0;
    rsp_kind = 1; rsp_delay = 0;
    set_m(0, 1, 1, 0, 4'h1, 32'h700, 32'h0);
    set_m(2, 1, 1, 0, 4'h1, 32'h800, 32'h0);
    wait_sig(2, 0, "rw_pulse2");
    chk("rw_first_m0", 32'(grant_o), 32'd1);
    drop_all(); repeat (5) step();

    // Randomized traffic
    rand_mode = 1;
    for (int c = 0; c < 3000; c++) begin
      for (int m = 0; m < N; m++) begin
        if ($urandom_range(0, 5) == 0) active[m] = !active[m];
        if (active[m]) begin
          if (!wbm_cyc_i[m])
            set_m(m, 1, 1, 1'($urandom_range(0, 1)), 4'($urandom), $urandom, $urandom);
          wbm_stb_i[m] = ($urandom_range(0, 7) != 0);
        end else begin
          wbm_cyc_i[m] = 1'b0;
          wbm_stb_i[m] = 1'($urandom_range(0, 1));
        end
      end
      wb_rst_i = ($urandom_range(0, 399) == 0);
      step();
    end
    rand_mode = 0; wb_rst_i = 1'b0;
    drop_all();
    repeat (20) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
